axi4_lite_master: RTL
=====================

Name: axi4_lite_master

Overview:
AXI4-Lite initiator that converts a simple single-command local interface into AXI4-Lite write (AW/W/B) and read (AR/R) transactions. It drives the register-bank slave used in the same subsystem and is the bus-side front end for CPU-less control logic and testbench drivers. Only one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 4, width of cmd_addr, AWADDR and ARADDR
DATA_WIDTH, 32, width of write and read data; fixed at 32 for AXI4-Lite

Ports:
ACLK  in  1  clock; all logic is rising-edge.
ARESETn  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  local command request.
cmd_ready  out  1  high only in IDLE. A command is accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
rsp_valid  out  1  one-cycle completion pulse.
rsp_write  out  1  type of the completed transaction.
rsp_resp  out  2  BRESP or RRESP captured from the slave.
rsp_rdata  out  DATA_WIDTH  read data; holds its last value for writes.
AWADDR  out  ADDR_WIDTH  write address.
AWVALID  out  1  write address valid.
AWREADY  in  1  write address ready.
WDATA  out  DATA_WIDTH  write data.
WSTRB  out  4  write strobes; constant 4'hF.
WVALID  out  1  write data valid.
WREADY  in  1  write data ready.
BRESP  in  2  write response.
BVALID  in  1  write response valid.
BREADY  out  1  write response ready.
ARADDR  out  ADDR_WIDTH  read address.
ARVALID  out  1  read address valid.
ARREADY  in  1  read address ready.
RDATA  in  DATA_WIDTH  read data.
RRESP  in  2  read response.
RVALID  in  1  read data valid.
RREADY  out  1  read data ready.

Behaviour:
- Reset values: AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid = 0. AWADDR, ARADDR, WDATA, rsp_rdata, rsp_resp, rsp_write = 0. State = IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops every VALID/READY immediately and returns to IDLE; no response is issued.
- All AXI outputs and rsp_* are registered, with no combinational path from any input to any output.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: cmd_ready = 1. On acceptance, register addr/wdata into AWADDR/WDATA or ARADDR.
  - Write goes to WR_ADDR_DATA with AWVALID = WVALID = 1 from the next cycle.
  - Read goes to RD_ADDR with ARVALID = 1.
- WR_ADDR_DATA: AW and W are tracked independently with done flags.
  - AWVALID clears on the cycle after AWVALID && AWREADY is sampled; WVALID likewise with WREADY.
  - Both handshakes may occur in the same cycle or in either order.
  - Once both are done, go to WR_RESP.
  - VALID, address and data stay stable until their handshake (AXI rule); there is no timeout or abort.
- WR_RESP: BREADY = 1. On BVALID && BREADY:
  - capture BRESP into rsp_resp; set rsp_write = 1;
  - pulse rsp_valid for exactly 1 cycle; drop BREADY; go to IDLE.
  - BVALID received outside WR_RESP is not acknowledged.
- RD_ADDR: hold ARVALID until ARVALID && ARREADY, then go to RD_DATA with RREADY = 1.
- RD_DATA: on RVALID && RREADY:
  - capture RDATA into rsp_rdata and RRESP into rsp_resp; set rsp_write = 0;
  - pulse rsp_valid; drop RREADY; go to IDLE.
- Minimum latency (slave READY and VALID responses immediate), with the command accepted at edge T0:
  - AW/W handshake or AR handshake at edge T1;
  - B or R handshake at edge T2;
  - rsp_valid high for the cycle following T2.
- cmd_ready is 0 throughout the cycle in which rsp_valid is high. A new command can be accepted one cycle after rsp_valid.
- A non-OKAY response (2'b10, 2'b11) is passed through unchanged and does not alter FSM flow.

Test Plan:
- Write 0xDEADBEEF to addr 0x4, slave READY immediate, BRESP=00 -> AWADDR=0x4, WDATA=0xDEADBEEF, WSTRB=4'hF each valid for 1 cycle; rsp_valid one cycle with rsp_write=1, rsp_resp=00; total 3 cycles from acceptance to end of rsp_valid.
- Write with AWREADY delayed 3 cycles and WREADY delayed 1 cycle -> WVALID drops after its handshake; AWVALID/AWADDR held stable for 4 cycles; BREADY asserted only after both done.
- Read addr 0x8, slave returns RDATA=0x12345678 with RVALID delayed 2 cycles, RRESP=00 -> ARVALID held until ARREADY; RREADY high until RVALID; rsp_rdata=0x12345678, rsp_write=0.
- Back-to-back write 0xA5A5A5A5 to 0xC then read 0xC, cmd_valid held high -> second command accepted exactly one cycle after the first rsp_valid; read returns 0xA5A5A5A5.
- BRESP=2'b10 on a write, RRESP=2'b11 on a read -> rsp_resp=10 and 11 respectively; FSM returns to IDLE normally.
- ARESETn asserted while AWVALID=1 and WVALID=1 mid-write -> all VALID/READY and rsp_valid drop asynchronously; no rsp_valid after release; cmd_ready=1 on the first cycle after reset release.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one local command at a time into an AW/W/B write
// or an AR/R read, and reports completion with a one-cycle rsp_valid pulse.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [3:0]            WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4
  } state_t;

  state_t r_state, w_state_next;

  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rsp_rdata;
  logic                  r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic                  r_aw_done, r_w_done;
  logic                  r_rsp_valid, r_rsp_write;
  logic [1:0]            r_rsp_resp;

  // A transfer happens on any rising edge where VALID and READY are both high;
  // a VALID and its payload never change until that edge has occurred.
  logic w_accept, w_aw_hs, w_w_hs, w_wr_done, w_b_hs, w_ar_hs, w_r_hs;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_aw_hs   = r_awvalid && AWREADY;
  assign w_w_hs    = r_wvalid && WREADY;
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_b_hs    = r_bready && BVALID;
  assign w_ar_hs   = r_arvalid && ARREADY;
  assign w_r_hs    = r_rready && RVALID;

  // Ready is withheld during the response pulse so the next accept lands one cycle later.
  assign cmd_ready   = (r_state == IDLE) && !r_rsp_valid;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_resp    = r_rsp_resp;
  assign rsp_rdata   = r_rsp_rdata;
  assign AWADDR      = r_awaddr;
  assign AWVALID     = r_awvalid;
  assign WDATA       = r_wdata;
  assign WSTRB       = 4'hF;
  assign WVALID      = r_wvalid;
  assign BREADY      = r_bready;
  assign ARADDR      = r_araddr;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;
  assign o_dbg_state = r_state;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:         if (w_accept) w_state_next = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (w_wr_done) w_state_next = WR_RESP;
      WR_RESP:      if (w_b_hs) w_state_next = IDLE;
      RD_ADDR:      if (w_ar_hs) w_state_next = RD_DATA;
      RD_DATA:      if (w_r_hs) w_state_next = IDLE;
      default:      w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_resp  <= 2'b00;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_wr_done) r_bready <= 1'b1;
        end
        WR_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
